timer_counter: RTL and testbench

//  Memory-mapped down-counting timer on the system bridge; drives one bit of the

---
 rtl/timer_counter_pkg.sv | 17 +
 rtl/timer_counter.sv | 67 ++++++
 tb/tb_timer_counter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/timer_counter_pkg.sv
// timer_counter_pkg: register offsets, mode codes, FSM states and CTRL layout for the bus timer
package timer_counter_pkg;
  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;
  localparam logic [1:0] TC_MODE0  = 2'd0;
  localparam logic [1:0] TC_MODE1  = 2'd1;
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOAD      = 2'd1;
  localparam logic [1:0] CNT       = 2'd2;
  localparam logic [1:0] INT       = 2'd3;
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;
endpackage

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counting timer, one-shot level IRQ or auto-reload pulse IRQ
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        We,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ
);
  ctrl_t            ctrl;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count;
  logic             irq_r;
  logic [1:0]       state;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl   <= '0;
      preset <= '0;
      count  <= '0;
      irq_r  <= 1'b0;
      state  <= IDLE;
    end else begin
      case (state)
        IDLE: if (ctrl.en) state <= LOAD;
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!ctrl.en) state <= IDLE;
          else if (count > CNT_W'(1)) count <= count - CNT_W'(1);
          else begin
            count <= '0;
            irq_r <= 1'b1;
            state <= INT;
          end
        end
        default: begin
          if (ctrl.mode == TC_MODE1) begin
            irq_r <= 1'b0;
            state <= LOAD;
          end else begin
            ctrl.en <= 1'b0;
            state   <= IDLE;
          end
        end
      endcase
      // bus writes come last so a CTRL write beats the one-shot EN clear
      if (We && Addr == TC_CTRL) begin
        ctrl  <= DIn[3:0];
        irq_r <= 1'b0;
      end
      if (We && Addr == TC_PRESET) preset <= CNT_W'(DIn);
    end
  end
  always_comb begin
    DOut = Addr == TC_CTRL   ? {28'b0, ctrl} :
           Addr == TC_PRESET ? 32'(preset)   :
           Addr == TC_COUNT  ? 32'(count)    : '0;
    IRQ  = irq_r & ctrl.im;
  end
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed register table plus hand-timed sequences for the timer modes
module tb_timer_counter;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  Addr;
  logic        We;
  logic [31:0] DIn;
  logic [31:0] DOut;
  logic        IRQ;
  int total = 0;
  int bad = 0;
  int cnt_seq[5] = '{3, 2, 1, 0, 0};
  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [1:0]  ra;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[12];
  timer_counter dut (
    .clk(clk), .reset(reset), .Addr(Addr), .We(We), .DIn(DIn), .DOut(DOut), .IRQ(IRQ)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic rd(input string nm, input logic [1:0] a, input logic [31:0] exp);
    Addr = a;
    #1;
    chk(nm, DOut, exp);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a;
    DIn  = d;
    We   = 1'b1;
    tick(1);
    We   = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask
  // entered one half-cycle after the enabling CTRL write edge
  task automatic oneshot(input int p, input string nm);
    for (int n = 0; n <= p + 1; n++) begin
      chk($sformatf("%s_irq_low_n%0d", nm, n), {31'b0, IRQ}, 32'd0);
      if (n == 2) rd($sformatf("%s_count_load", nm), 2'd2, p);
      tick(1);
    end
    chk($sformatf("%s_irq_high", nm), {31'b0, IRQ}, 32'd1);
  endtask
  initial begin
    reset = 1'b1;
    We    = 1'b0;
    Addr  = 2'd0;
    DIn   = '0;
    tick(2);
    reset = 1'b0;
    vecs[0]  = '{1'b0, 2'd0, 32'h0,        2'd0, 32'h0};
    vecs[1]  = '{1'b0, 2'd0, 32'h0,        2'd1, 32'h0};
    vecs[2]  = '{1'b0, 2'd0, 32'h0,        2'd2, 32'h0};
    vecs[3]  = '{1'b0, 2'd0, 32'h0,        2'd3, 32'h0};
    vecs[4]  = '{1'b1, 2'd1, 32'hDEADBEEF, 2'd1, 32'hDEADBEEF};
    vecs[5]  = '{1'b1, 2'd0, 32'hFFFFFFF6, 2'd0, 32'h6};
    vecs[6]  = '{1'b1, 2'd2, 32'h1234,     2'd2, 32'h0};
    vecs[7]  = '{1'b1, 2'd3, 32'hFFFF,     2'd3, 32'h0};
    vecs[8]  = '{1'b1, 2'd0, 32'h8,        2'd0, 32'h8};
    vecs[9]  = '{1'b0, 2'd0, 32'h0,        2'd1, 32'hDEADBEEF};
    vecs[10] = '{1'b1, 2'd1, 32'h0,        2'd1, 32'h0};
    vecs[11] = '{1'b1, 2'd0, 32'h0,        2'd0, 32'h0};
    foreach (vecs[i]) begin
      Addr = vecs[i].addr;
      DIn  = vecs[i].din;
      We   = vecs[i].we;
      tick(1);
      We = 1'b0;
      rd($sformatf("vec%0d", i), vecs[i].ra, vecs[i].exp);
      chk($sformatf("vec%0d_irq", i), {31'b0, IRQ}, 32'd0);
    end
    // async reset in the middle of a count
    do_reset();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    tick(4);
    rd("pre_reset_count", 2'd2, 32'd8);
    reset = 1'b1;
    rd("async_count", 2'd2, 32'd0);
    rd("async_ctrl", 2'd0, 32'd0);
    rd("async_preset", 2'd1, 32'd0);
    chk("async_irq", {31'b0, IRQ}, 32'd0);
    tick(1);
    reset = 1'b0;
    tick(3);
    rd("post_reset_count", 2'd2, 32'd0);
    // one-shot mode 0
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    oneshot(5, "m0a");
    tick(1);
    rd("m0_ctrl_en_clr", 2'd0, 32'h8);
    rd("m0_count_zero", 2'd2, 32'd0);
    chk("m0_irq_held", {31'b0, IRQ}, 32'd1);
    tick(2);
    chk("m0_irq_held2", {31'b0, IRQ}, 32'd1);
    wr(2'd0, 32'h9);
    oneshot(5, "m0b");
    wr(2'd0, 32'h9);
    rd("int_write_wins", 2'd0, 32'h9);
    oneshot(5, "m0c");
    // auto-reload pulses, period preset+2
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int n = 0; n <= 51; n++) begin
      chk($sformatf("m1_irq_n%0d", n), {31'b0, IRQ}, (n >= 5 && n % 5 == 0) ? 32'd1 : 32'd0);
      tick(1);
    end
    // IM=0 masks IRQ but not counting
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h3);
    tick(2);
    for (int k = 0; k <= 10; k++) begin
      rd($sformatf("masked_count_k%0d", k), 2'd2, cnt_seq[k % 5]);
      chk($sformatf("masked_irq_k%0d", k), {31'b0, IRQ}, 32'd0);
      tick(1);
    end
    // disable freezes, re-enable reloads from preset
    do_reset();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    tick(5);
    rd("frz_count7", 2'd2, 32'd7);
    wr(2'd0, 32'h0);
    rd("frz_count6", 2'd2, 32'd6);
    tick(4);
    rd("frz_hold", 2'd2, 32'd6);
    rd("frz_ctrl", 2'd0, 32'd0);
    wr(2'd0, 32'h1);
    rd("reen_n0", 2'd2, 32'd6);
    tick(1);
    rd("reen_n1", 2'd2, 32'd6);
    tick(1);
    rd("reen_reload", 2'd2, 32'd10);
    // COUNT writes ignored, PRESET change lands at next reload
    do_reset();
    wr(2'd1, 32'd8);
    wr(2'd0, 32'h3);
    tick(3);
    rd("pw_count7", 2'd2, 32'd7);
    wr(2'd2, 32'h55);
    rd("pw_count_ro", 2'd2, 32'd6);
    wr(2'd1, 32'd2);
    rd("pw_count5", 2'd2, 32'd5);
    rd("pw_preset", 2'd1, 32'd2);
    tick(7);
    rd("pw_reload2", 2'd2, 32'd2);
    tick(1);
    rd("pw_reload1", 2'd2, 32'd1);
    tick(1);
    rd("pw_reload0", 2'd2, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
